mux4_sync: RTL and testbench
============================

Name: mux4_sync

Overview:
- Registered 4-to-1 multiplexer with a valid/ready pipeline stage.
- Selects one of four WIDTH-bit data inputs by a 2-bit select and presents the result one clock later.
- Provides full backpressure so it can sit inline in a streaming datapath between a producer and a consumer.
- The select value is carried alongside the data for downstream tagging.

Parameters:
- WIDTH, 8, bit width of each data input and of the data output.

Ports:
- i_clk  input  1  single clock; all logic on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_val0  input  WIDTH  data input 0.
- i_val1  input  WIDTH  data input 1.
- i_val2  input  WIDTH  data input 2.
- i_val3  input  WIDTH  data input 3.
- i_sel  input  2  select: 0→i_val0, 1→i_val1, 2→i_val2, 3→i_val3.
- i_valid  input  1  upstream asserts when inputs and select are valid.
- o_ready  output  1  block can accept an input this cycle.
- o_val  output  WIDTH  registered selected data.
- o_sel  output  2  registered copy of the select that produced o_val.
- o_valid  output  1  o_val/o_sel hold valid data.
- i_ready  input  1  downstream can accept output this cycle.

Behaviour:
- Reset:
  - Evaluated on the rising edge of i_clk while i_rst_n=0.
  - o_valid=0, o_val=0, o_sel=0.
  - Reset has priority over every other event.
  - Any held output is discarded, including on reset mid-transfer.
- o_ready is combinational: o_ready = !o_valid || i_ready. There is no combinational path from data or select inputs to any output.
- Accept condition: i_valid && o_ready at a rising edge. On accept:
  - o_val <= input selected by i_sel.
  - o_sel <= i_sel.
  - o_valid <= 1.
- Latency: exactly 1 cycle from accept to the result on o_val with o_valid=1.
- Drain condition: o_valid && i_ready.
  - Drain without a same-cycle accept gives o_valid <= 0.
  - o_val and o_sel keep their last value; don't-care for the consumer, but they must not change.
- Simultaneous drain and accept: the new value replaces the old in the same edge; o_valid stays 1. Full throughput is one transfer per cycle.
- Stall (o_valid=1, i_ready=0):
  - o_val, o_sel and o_valid are held bit-stable.
  - o_ready=0.
  - Input changes are ignored.
- i_valid=0: no state change except the drain.
- Selection is a pure 4-way choice with no arithmetic; widths are equal, with no truncation or extension.
- i_sel wraps naturally 3→0; every 2-bit code is legal, so there is no out-of-range case.
- Upstream need not hold inputs stable once the accept has occurred.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1 → o_valid=0, o_val=0x00, o_sel=0; after release with i_ready=1, the first edge accepts.
- Select sweep: WIDTH=8, i_val0..3=0,1,2,3, i_ready=1, i_valid=1, i_sel stepping 0,1,2,3,0 each cycle → o_val=0,1,2,3,0 one cycle after each select, o_sel matches, o_valid=1 throughout.
- Distinct patterns: i_val0..3=0xA5,0x5A,0xFF,0x00, all selects → o_val equals the chosen pattern exactly, with no bit mixing from the other inputs.
- Backpressure: accept sel=2 (o_val=2), then i_ready=0 for 3 cycles while i_sel and inputs change → o_val=2 and o_valid=1 held, o_ready=0; on i_ready=1 the pending input is accepted that edge.
- Bubble: i_valid=0 for one cycle with i_ready=1 → o_valid drops to 0 for one cycle, then returns with the next accepted value.
- Reset mid-stall: o_valid=1, i_ready=0, assert i_rst_n=0 for one edge → o_valid=0, o_val=0, o_sel=0 on that edge.

Source files
------------

// File: rtl/mux4_sync.sv
// Registered 4-to-1 mux with a single valid/ready skid-free pipeline stage.
// The select travels with the data so downstream can tag the result.
module mux4_sync #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_val0,
    input  logic [WIDTH-1:0] i_val1,
    input  logic [WIDTH-1:0] i_val2,
    input  logic [WIDTH-1:0] i_val3,
    input  logic [1:0]       i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_val,
    output logic [1:0]       o_sel,
    output logic             o_valid,
    input  logic             i_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic [1:0]       sel;
    } rsp_t;

    rsp_t             rsp_q;
    logic             vld_q;
    logic [WIDTH-1:0] mux_d;
    logic             accept;

    always_comb begin
        mux_d = '0;
        case (i_sel)
            2'd0: mux_d = i_val0;
            2'd1: mux_d = i_val1;
            2'd2: mux_d = i_val2;
            2'd3: mux_d = i_val3;
            default: mux_d = '0;
        endcase
    end

    assign o_ready = !vld_q || i_ready;
    assign accept  = i_valid && o_ready;

    // A drain with no new accept only clears valid; the payload stays put.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
        end else if (accept) begin
            vld_q     <= 1'b1;
            rsp_q.val <= mux_d;
            rsp_q.sel <= i_sel;
        end else if (i_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign o_val   = rsp_q.val;
    assign o_sel   = rsp_q.sel;
    assign o_valid = vld_q;

endmodule

// File: tb/tb_mux4_sync.sv
// Directed bench for mux4_sync: reset, select sweep, patterns, backpressure,
// bubble and reset during a stall.
module tb_mux4_sync;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] v0, v1, v2, v3;
    logic [1:0]       sel;
    logic             valid;
    logic             ready_out;
    logic [WIDTH-1:0] oval;
    logic [1:0]       osel;
    logic             ovalid;
    logic             dready;

    int vectors = 0;
    int errs    = 0;

    mux4_sync #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_val0  (v0),
        .i_val1  (v1),
        .i_val2  (v2),
        .i_val3  (v3),
        .i_sel   (sel),
        .i_valid (valid),
        .o_ready (ready_out),
        .o_val   (oval),
        .o_sel   (osel),
        .o_valid (ovalid),
        .i_ready (dready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        v0 = a; v1 = b; v2 = c; v3 = d;
    endtask

    initial begin
        logic [7:0] pat [4];
        pat = '{8'hA5, 8'h5A, 8'hFF, 8'h00};

        // Reset held two edges with valid asserted
        rst_n = 1'b0; valid = 1'b1; dready = 1'b1; sel = 2'd1;
        set_vals(8'h11, 8'h22, 8'h33, 8'h44);
        step(); step();
        chk("rst_valid", 32'(ovalid), 32'd0);
        chk("rst_val",   32'(oval),   32'h00);
        chk("rst_sel",   32'(osel),   32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);

        // Select sweep 0,1,2,3,0
        rst_n = 1'b1;
        set_vals(8'd0, 8'd1, 8'd2, 8'd3);
        for (int k = 0; k < 5; k++) begin
            sel = 2'(k);
            step();
            chk("sweep_val",   32'(oval),   32'(k % 4));
            chk("sweep_sel",   32'(osel),   32'(k % 4));
            chk("sweep_valid", 32'(ovalid), 32'd1);
        end

        // Distinct bit patterns
        set_vals(pat[0], pat[1], pat[2], pat[3]);
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            step();
            chk("pat_val", 32'(oval), 32'(pat[k]));
            chk("pat_sel", 32'(osel), 32'(k));
        end

        // Backpressure: accept sel=2, then stall 3 cycles with changing inputs
        set_vals(8'd0, 8'd1, 8'd2, 8'd3);
        sel = 2'd2;
        step();
        chk("bp_first", 32'(oval), 32'd2);
        dready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            set_vals(8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k), 8'(8'h70 + k));
            #1;
            chk("bp_ready", 32'(ready_out), 32'd0);
            step();
            chk("bp_hold_val",   32'(oval),   32'd2);
            chk("bp_hold_sel",   32'(osel),   32'd2);
            chk("bp_hold_valid", 32'(ovalid), 32'd1);
        end
        sel = 2'd3;
        set_vals(8'h30, 8'h31, 8'h32, 8'h33);
        dready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ready_out), 32'd1);
        step();
        chk("bp_release_val", 32'(oval), 32'h33);
        chk("bp_release_sel", 32'(osel), 32'd3);

        // Bubble: one idle cycle, payload must stay put
        valid = 1'b0;
        sel = 2'd0;
        set_vals(8'h99, 8'h98, 8'h97, 8'h96);
        step();
        chk("bubble_valid", 32'(ovalid), 32'd0);
        chk("bubble_val",   32'(oval),   32'h33);
        chk("bubble_sel",   32'(osel),   32'd3);
        valid = 1'b1;
        sel = 2'd1;
        step();
        chk("bubble_resume_valid", 32'(ovalid), 32'd1);
        chk("bubble_resume_val",   32'(oval),   32'h98);

        // Reset in the middle of a stall
        dready = 1'b0;
        sel = 2'd2;
        step();
        chk("stall_pre_val", 32'(oval), 32'h98);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(ovalid), 32'd0);
        chk("midrst_val",   32'(oval),   32'h00);
        chk("midrst_sel",   32'(osel),   32'd0);
        rst_n = 1'b1;
        dready = 1'b1;
        step();
        chk("post_rst_val", 32'(oval), 32'h97);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
